// File: rtl/uart_tx_frame_ctrl_if.sv
// Byte-level link between the frame sequencer and uart_byte_tx.
// master = sequencer side, slave = byte transmitter side.
interface uart_tx_frame_ctrl_if;
  logic [7:0] tx_data_byte;
  logic       tx_send_en;
  logic [2:0] tx_baud_set;
  logic       tx_done;
  logic       tx_state;

  modport master (
    output tx_data_byte, tx_send_en, tx_baud_set,
    input  tx_done, tx_state
  );

  modport slave (
    input  tx_data_byte, tx_send_en, tx_baud_set,
    output tx_done, tx_state
  );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// Frame sequencer for uart_byte_tx: buffers payload bytes, then sends
// HEADER, LEN, payload, CHECKSUM one byte per tx_done, with a stall watchdog.
module uart_tx_frame_ctrl #(
  parameter int unsigned Depth   = 16,
  parameter logic [7:0]  Header  = 8'h55,
  parameter logic [2:0]  BaudSet = 3'd0,
  parameter int unsigned Timeout = 100000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en_i,
  input  logic [7:0]                   wr_data_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic [$clog2(Depth+1)-1:0]   fill_cnt_o,
  output logic                         frame_done_o,
  output logic                         err_timeout_o,
  uart_tx_frame_ctrl_if.master         tx_if
);

  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
  localparam logic [31:0]     WdogMax = 32'(Timeout - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StAbort} state_e;

  state_e          state_q;
  logic            busy_q, frame_done_q, err_q;
  logic [7:0]      data_q, csum_q;
  logic [CntW-1:0] fill_q, len_q;
  logic [8:0]      idx_q;
  logic [31:0]     wdog_q;
  logic [7:0]      buf_q [Depth];

  logic [8:0] idx_next, last_idx;
  logic [7:0] next_byte;
  logic       add_csum;

  // Byte for the index that follows the one just acknowledged.
  always_comb begin
    idx_next  = idx_q + 9'd1;
    last_idx  = 9'(len_q) + 9'd2;
    add_csum  = 1'b1;
    if (idx_next == 9'd1) begin
      next_byte = 8'(len_q);
    end else if (idx_next < last_idx) begin
      next_byte = buf_q[AddrW'(idx_next - 9'd2)];
    end else begin
      next_byte = csum_q;
      add_csum  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StIdle && !start_i && wr_en_i && fill_q < DepthC) begin
      buf_q[AddrW'(fill_q)] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= 8'h00;
      csum_q       <= 8'h00;
      fill_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      wdog_q       <= '0;
    end else begin
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StIssue;
            busy_q  <= 1'b1;
            len_q   <= fill_q;
            idx_q   <= '0;
            csum_q  <= 8'h00;
            data_q  <= Header;
          end else if (wr_en_i && fill_q < DepthC) begin
            fill_q <= fill_q + CntW'(1);
          end
        end
        StIssue: begin
          if (!tx_if.tx_state) begin
            state_q <= StWait;
            wdog_q  <= '0;
          end
        end
        StWait: begin
          if (tx_if.tx_done) begin
            if (idx_q == last_idx) begin
              state_q      <= StDone;
              frame_done_q <= 1'b1;
            end else begin
              state_q <= StIssue;
              idx_q   <= idx_next;
              data_q  <= next_byte;
              if (add_csum) csum_q <= csum_q + next_byte;
            end
          end else if (wdog_q == WdogMax) begin
            state_q <= StAbort;
            err_q   <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 32'd1;
          end
        end
        StDone, StAbort: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          fill_q  <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o             = busy_q;
  assign fill_cnt_o         = fill_q;
  assign frame_done_o       = frame_done_q;
  assign err_timeout_o      = err_q;
  assign tx_if.tx_data_byte = data_q;
  assign tx_if.tx_send_en   = (state_q == StIssue) && !tx_if.tx_state;
  assign tx_if.tx_baud_set  = BaudSet;

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
- Frame sequencer that sits in front of uart_byte_tx and drives its data_byte, send_en and baud_set inputs.
- A user loads payload bytes into an internal buffer, then pulses start. The block then sends one frame: HEADER, LEN, payload[0..LEN-1], CHECKSUM.
- It issues one send_en per byte and waits for tx_done before sending the next byte.
- A watchdog aborts the frame if uart_byte_tx stalls.

Parameters:
- DEPTH, 16, payload buffer depth in bytes; must be ≥1 and ≤255.
- HEADER, 8'h55, first byte of every frame.
- BAUD_SET, 3'd0, constant driven on tx_baud_set.
- TIMEOUT, 100000, maximum clk cycles in WAIT without tx_done before abort; must exceed one byte time (52083 cycles at 9600 baud, 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  reset; synchronous, active-low
- wr_en  in  1  write wr_data into the payload buffer
- wr_data  in  8  payload byte
- start  in  1  request frame transmission (level sampled, acted on once)
- busy  out  1  high from the cycle after start is accepted until the frame ends
- fill_cnt  out  $clog2(DEPTH+1)  number of buffered payload bytes
- frame_done  out  1  one-cycle pulse on successful completion
- err_timeout  out  1  one-cycle pulse on abort
- tx_data_byte  out  8  to uart_byte_tx data_byte
- tx_send_en  out  1  to uart_byte_tx send_en
- tx_baud_set  out  3  to uart_byte_tx baud_set, tied to BAUD_SET
- tx_done  in  1  from uart_byte_tx tx_done, one-cycle pulse
- tx_state  in  1  from uart_byte_tx uart_state, high while transmitting

Behaviour:
- Reset (reset_n low at a clk edge), including mid-frame:
  - state=IDLE; busy, frame_done, err_timeout, tx_send_en = 0.
  - tx_data_byte = 8'h00; fill_cnt = 0; byte index and watchdog = 0.
  - Buffer contents are don't-care. No further send_en is issued.
- States: IDLE, ISSUE, WAIT, DONE, ABORT.
- IDLE:
  - wr_en with fill_cnt<DEPTH writes buffer[fill_cnt] and increments fill_cnt.
  - wr_en with fill_cnt==DEPTH is dropped silently; fill_cnt stays at DEPTH.
  - start moves to ISSUE, captures LEN=fill_cnt, sets index=0 and clears the checksum accumulator.
  - start and wr_en in the same cycle: start wins and that write is dropped.
  - start with fill_cnt=0 is legal and sends a zero-length frame.
- Byte index sequence:
  - 0 → HEADER
  - 1 → LEN
  - 2..LEN+1 → buffer[index-2]
  - LEN+2 → CHECKSUM
- CHECKSUM = (LEN + sum of payload bytes) mod 256, 8-bit wrap. HEADER is excluded.
- ISSUE:
  - tx_data_byte is loaded with the byte for the current index.
  - tx_send_en is asserted for exactly one cycle, the first ISSUE cycle in which tx_state==0. The state then moves to WAIT.
  - While tx_state==1, the block holds in ISSUE with send_en low.
  - tx_done seen in ISSUE is ignored.
- WAIT:
  - tx_data_byte is held stable.
  - The watchdog increments each cycle and clears on entry to WAIT.
  - tx_done: if index==LEN+2, go to DONE; otherwise increment index and go to ISSUE.
  - Watchdog reaching TIMEOUT-1 without tx_done: go to ABORT. If tx_done arrives in the same cycle, tx_done wins.
- DONE: frame_done=1 for one cycle, fill_cnt←0, go to IDLE.
- ABORT: err_timeout=1 for one cycle, fill_cnt←0, go to IDLE; frame_done is not pulsed.
- busy = 1 in ISSUE, WAIT, DONE and ABORT. wr_en and start are ignored while busy.
- Latency:
  - start sampled at edge N → tx_send_en high in cycle N+1 (if tx_state=0).
  - tx_done at edge k → next send_en at k+1.
  - Final tx_done at edge k → frame_done at k+1, busy low at k+2.
- A frame is exactly LEN+3 send_en pulses.

Test Plan:
- Write 8'h01, 8'h02, 8'hFE, then start → send_en pulses carry 55, 03, 01, 02, FE, 04 (checksum 0x104 wraps to 0x04); frame_done once; fill_cnt returns to 0.
- start with empty buffer → bytes 55, 00, 00; 3 send_en pulses; frame_done.
- Write DEPTH+2 bytes → fill_cnt saturates at DEPTH; frame LEN=DEPTH; the last 2 writes are absent from the frame.
- Model never returns tx_done after the 2nd byte → err_timeout pulses exactly TIMEOUT cycles after WAIT entry; no frame_done; busy falls; fill_cnt=0.
- During a frame: start and wr_en pulses, plus tx_state held high for 10 cycles before byte 3 → no extra frames or writes; send_en delayed until tx_state falls; byte order unchanged.
- reset_n low for 1 cycle during WAIT of byte 2 → all outputs at reset values the next cycle; no further send_en; a subsequent frame sends correctly.
